// File: rtl/cap_seq_pkg.sv
// Shared types and defaults for the capacitor charge sequencer: state encoding,
// default widths and the charge/discharge current magnitude.
package cap_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHARGE    = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_DISCHARGE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CHARGE    = ST_CHARGE,
    S_HOLD      = ST_HOLD,
    S_DISCHARGE = ST_DISCHARGE,
    S_DONE      = ST_DONE,
    S_FAULT     = ST_FAULT
  } cap_seq_state_e;

  localparam int unsigned        CAP_SEQ_TS_DIV     = 4;
  localparam int unsigned        CAP_SEQ_IW         = 16;
  localparam int unsigned        CAP_SEQ_VW         = 16;
  localparam int unsigned        CAP_SEQ_HOLD_TICKS = 8;
  localparam int unsigned        CAP_SEQ_NCYC_W     = 8;
  localparam logic signed [15:0] CAP_SEQ_I_MAG      = 16'sd1000;

  // True for the states that drive or hold charge on the integrator.
  function automatic logic is_phase(input cap_seq_state_e s);
    return (s == S_CHARGE) || (s == S_HOLD) || (s == S_DISCHARGE);
  endfunction

endpackage

// File: rtl/cap_charge_sequencer_tick.sv
// Sample-period timebase: modulo-TS_DIV counter emitting a one-clock tick,
// restartable so the first tick after a restart lands TS_DIV clocks later.
module cap_tick_gen #(
  parameter int unsigned TS_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (r_cnt == CW'(TS_DIV - 1)) begin
      r_cnt  <= '0;
      o_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/cap_charge_sequencer.sv
// Charge/hold/discharge sequencer for the capacitor integrator; phase decisions
// are taken once per sample tick. Optional phase timeout: CAP_SEQ_TIMEOUT_EN.
//
// state      | meaning
// IDLE      0 | waiting for start, i_set = 0
// CHARGE    1 | i_set = +I_MAG until v_meas >= v_high on a tick
// HOLD      2 | i_set = 0 for HOLD_TICKS ticks
// DISCHARGE 3 | i_set = -I_MAG until v_meas <= v_low on a tick
// DONE      4 | one clock, pulses done
// FAULT     5 | phase timeout, left only by abort or rst
module cap_charge_sequencer
  import cap_seq_pkg::*;
#(
  parameter int unsigned          TS_DIV     = CAP_SEQ_TS_DIV,
  parameter int unsigned          IW         = CAP_SEQ_IW,
  parameter int unsigned          VW         = CAP_SEQ_VW,
  parameter logic signed [IW-1:0] I_MAG      = CAP_SEQ_I_MAG,
  parameter int unsigned          HOLD_TICKS = CAP_SEQ_HOLD_TICKS,
  parameter int unsigned          NCYC_W     = CAP_SEQ_NCYC_W
`ifdef CAP_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned          TO_TICKS   = 4096
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NCYC_W-1:0]        n_cycles,
  input  logic signed [VW-1:0]     v_high,
  input  logic signed [VW-1:0]     v_low,
  input  logic signed [VW-1:0]     v_meas,
  output logic signed [IW-1:0]     i_set,
  output logic                     sample_tick,
  output logic [2:0]               state,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic [NCYC_W-1:0]        cyc_cnt,
  output logic                     fault
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  cap_seq_state_e    r_state;
  cap_seq_state_e    w_state_nxt;
  logic [NCYC_W-1:0] r_ncyc;
  logic [HW-1:0]     r_hold_cnt;
  logic [NCYC_W:0]   w_cyc_inc;
  logic              w_thr_ok;
  logic              w_start_ok;
  logic              w_cfg_bad;
  logic              w_chg_end;
  logic              w_dis_end;
  logic              w_cyc_last;

  cap_tick_gen #(
    .TS_DIV(TS_DIV)
  ) u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_restart(w_start_ok),
    .o_tick   (sample_tick)
  );

  assign w_thr_ok   = (v_high > v_low);
  assign w_start_ok = (r_state == S_IDLE) && start && !abort && w_thr_ok;
  assign w_cfg_bad  = (r_state == S_IDLE) && start && !abort && !w_thr_ok;
  assign w_chg_end  = (r_state == S_CHARGE) && sample_tick && (v_meas >= v_high);
  assign w_dis_end  = (r_state == S_DISCHARGE) && sample_tick && (v_meas <= v_low);
  assign w_cyc_inc  = {1'b0, cyc_cnt} + (NCYC_W + 1)'(1);
  assign w_cyc_last = !(w_cyc_inc < {1'b0, r_ncyc});

`ifdef CAP_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_TICKS + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_fault;
  logic          w_to_hit;

  assign w_to_hit = sample_tick && (r_to_cnt == '0);

  // Reloaded on every CHARGE/DISCHARGE entry so each phase gets the full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (((w_state_nxt == S_CHARGE) || (w_state_nxt == S_DISCHARGE)) &&
                 (w_state_nxt != r_state)) begin
      r_to_cnt <= TW'(TO_TICKS - 1);
    end else if (((r_state == S_CHARGE) || (r_state == S_DISCHARGE)) &&
                 sample_tick && (r_to_cnt != '0)) begin
      r_to_cnt <= r_to_cnt - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (abort) begin
      r_fault <= 1'b0;
    end else if (w_state_nxt == S_FAULT) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_CHARGE;
      end
      S_CHARGE: begin
        if (w_chg_end) w_state_nxt = S_HOLD;
`ifdef CAP_SEQ_TIMEOUT_EN
        else if (w_to_hit) w_state_nxt = S_FAULT;
`endif
      end
      S_HOLD: begin
        if (sample_tick && (r_hold_cnt == '0)) w_state_nxt = S_DISCHARGE;
      end
      S_DISCHARGE: begin
        if (w_dis_end) w_state_nxt = w_cyc_last ? S_DONE : S_CHARGE;
`ifdef CAP_SEQ_TIMEOUT_EN
        else if (w_to_hit) w_state_nxt = S_FAULT;
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
`ifdef CAP_SEQ_TIMEOUT_EN
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so they move together with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      i_set   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= is_phase(w_state_nxt);
      done    <= (w_state_nxt == S_DONE);
      cfg_err <= w_cfg_bad;
      if (w_state_nxt == S_CHARGE) begin
        i_set <= I_MAG;
      end else if (w_state_nxt == S_DISCHARGE) begin
        i_set <= -I_MAG;
      end else begin
        i_set <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      r_ncyc  <= '0;
    end else if (w_start_ok) begin
      cyc_cnt <= '0;
      r_ncyc  <= (n_cycles == '0) ? NCYC_W'(1) : n_cycles;
    end else if (w_dis_end && !abort && (cyc_cnt != '1)) begin
      cyc_cnt <= w_cyc_inc[NCYC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if ((w_state_nxt == S_HOLD) && (r_state != S_HOLD)) begin
      r_hold_cnt <= HW'(HOLD_TICKS - 1);
    end else if ((r_state == S_HOLD) && sample_tick && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - HW'(1);
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_cap_charge_sequencer.sv
// Scoreboard bench for cap_charge_sequencer: a ramping plant drives v_meas and
// each expected phase (state, i_set, ticks spent, cyc_cnt) is queued at start.
`timescale 1ns/1ps
module tb_cap_charge_sequencer;
  import cap_seq_pkg::*;

  typedef struct {
    logic [2:0] st;
    int         iset;
    int         ticks;
    int         cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [7:0]         n_cycles;
  logic signed [15:0] v_high;
  logic signed [15:0] v_low;
  logic signed [15:0] v_meas;
  logic signed [15:0] i_set;
  logic               sample_tick;
  logic [2:0]         state;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [7:0]         cyc_cnt;
  logic               fault;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   plant_en = 1'b0;
  exp_t sb_q[$];
  int   n_done = 0;
  int   n_pos  = 0;
  int   n_neg  = 0;

  always #5 clk = ~clk;

  cap_charge_sequencer #(
    .TS_DIV    (4),
    .IW        (16),
    .VW        (16),
    .I_MAG     (16'sd1000),
    .HOLD_TICKS(8),
    .NCYC_W    (8)
`ifdef CAP_SEQ_TIMEOUT_EN
    ,
    .TO_TICKS  (16)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_cycles   (n_cycles),
    .v_high     (v_high),
    .v_low      (v_low),
    .v_meas     (v_meas),
    .i_set      (i_set),
    .sample_tick(sample_tick),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .cyc_cnt    (cyc_cnt),
    .fault      (fault)
  );

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] st, input int iset, input int ticks, input int cyc);
    exp_t e;
    e.st = st; e.iset = iset; e.ticks = ticks; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  // Plant-level prediction: ramp +/-50 per tick until each threshold is crossed.
  task automatic push_run(input int n, input int v0, input int vh, input int vl);
    int v, t, nn;
    v  = v0;
    nn = (n == 0) ? 1 : n;
    for (int k = 0; k < nn; k++) begin
      t = 0;
      do begin v += 50; t++; end while (v < vh && t < 10000);
      push_exp(ST_CHARGE, 1000, t, k);
      push_exp(ST_HOLD, 0, 8, k);
      t = 0;
      do begin v -= 50; t++; end while (v > vl && t < 10000);
      push_exp(ST_DISCHARGE, -1000, t, k);
    end
    push_exp(ST_DONE, 0, -1, nn);
    push_exp(ST_IDLE, 0, -1, nn);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int k;
    k = 0;
    while (state != st && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk_eq(tag, state, st);
  endtask

  task automatic wait_idle_empty(input int budget, input string tag);
    int k;
    k = 0;
    while (!(state == ST_IDLE && sb_q.size() == 0) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk_eq({tag, "_sb_left"}, sb_q.size(), 0);
    chk_eq({tag, "_idle"}, state, ST_IDLE);
  endtask

  initial begin : plant
    forever begin
      @(negedge clk);
      if (plant_en && sample_tick) begin
        if (i_set > 0) v_meas = v_meas + 16'sd50;
        else if (i_set < 0) v_meas = v_meas - 16'sd50;
      end
    end
  end

  initial begin : monitor
    logic [2:0] prev_st;
    int         tick_cnt;
    exp_t       cur;
    bit         cur_valid;
    prev_st   = ST_IDLE;
    tick_cnt  = 0;
    cur_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_st   = ST_IDLE;
        tick_cnt  = 0;
        cur_valid = 1'b0;
      end else begin
        if (state != prev_st) begin
          if (cur_valid && cur.ticks >= 0)
            chk_eq($sformatf("ticks_in_st%0d", cur.st), tick_cnt, cur.ticks);
          if (sb_q.size() == 0) begin
            chk_eq("unexpected_state", state, prev_st);
            cur_valid = 1'b0;
          end else begin
            cur = sb_q.pop_front();
            cur_valid = 1'b1;
            chk_eq("sb_state", state, cur.st);
            chk_eq("sb_iset", i_set, cur.iset);
            chk_eq("sb_busy", busy, (cur.st inside {ST_CHARGE, ST_HOLD, ST_DISCHARGE}));
            chk_eq("sb_cyc", cyc_cnt, cur.cyc);
            if (cur.st == ST_DONE) chk_eq("sb_done", done, 1);
          end
          if (i_set == 16'sd1000) n_pos++;
          if (i_set == -16'sd1000) n_neg++;
          tick_cnt = 0;
          prev_st  = state;
        end else if (cur_valid && i_set != cur.iset) begin
          chk_eq("iset_hold", i_set, cur.iset);
        end
        if (sample_tick) tick_cnt++;
        if (done) n_done++;
      end
    end
  end

  initial begin : stim
    int k;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    n_cycles = 8'd1;
    v_high   = 16'sd500;
    v_low    = 16'sd100;
    v_meas   = 16'sd0;

    repeat (3) @(negedge clk);
    chk_eq("rst_state", state, ST_IDLE);
    chk_eq("rst_iset", i_set, 0);
    chk_eq("rst_tick", sample_tick, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_cfg_err", cfg_err, 0);
    chk_eq("rst_fault", fault, 0);
    chk_eq("rst_cyc_cnt", cyc_cnt, 0);
    rst = 1'b0;

    k = 0;
    do begin @(negedge clk); k++; end while (!sample_tick && k < 20);
    chk_eq("tick_first_gap", k, 4);
    k = 0;
    do begin @(negedge clk); k++; end while (!sample_tick && k < 20);
    chk_eq("tick_period", k, 4);

    // single cycle
    n_done   = 0;
    plant_en = 1'b1;
    push_run(1, 0, 500, 100);
    pulse_start();
    chk_eq("single_no_cfg_err", cfg_err, 0);
    wait_idle_empty(2000, "single");
    chk_eq("single_done_cnt", n_done, 1);
    chk_eq("single_cyc_cnt", cyc_cnt, 1);

    // three cycles, with an ignored start while busy
    plant_en = 1'b0;
    v_meas   = 16'sd0;
    plant_en = 1'b1;
    n_cycles = 8'd3;
    n_done = 0; n_pos = 0; n_neg = 0;
    push_run(3, 0, 500, 100);
    pulse_start();
    wait_state(ST_HOLD, 400, "multi_reach_hold");
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    chk_eq("busy_start_no_cfg_err", cfg_err, 0);
    wait_idle_empty(4000, "multi");
    chk_eq("multi_pos_phases", n_pos, 3);
    chk_eq("multi_neg_phases", n_neg, 3);
    chk_eq("multi_done_cnt", n_done, 1);
    chk_eq("multi_cyc_cnt", cyc_cnt, 3);

    // n_cycles = 0 runs a single cycle
    plant_en = 1'b0;
    v_meas   = 16'sd0;
    plant_en = 1'b1;
    n_cycles = 8'd0;
    n_done   = 0;
    push_run(0, 0, 500, 100);
    pulse_start();
    wait_idle_empty(2000, "ncyc0");
    chk_eq("ncyc0_cyc_cnt", cyc_cnt, 1);
    chk_eq("ncyc0_done_cnt", n_done, 1);
    n_cycles = 8'd1;

    // rejected starts: equal thresholds, then a signed-only rejection
    v_high = 16'sd100;
    v_low  = 16'sd100;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk_eq("cfg_err_pulse", cfg_err, 1);
    chk_eq("cfg_err_state", state, ST_IDLE);
    @(negedge clk);
    chk_eq("cfg_err_one_clk", cfg_err, 0);
    v_high = -16'sd32768;
    v_low  = 16'sd0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk_eq("cfg_err_signed", cfg_err, 1);
    chk_eq("cfg_err_signed_state", state, ST_IDLE);

    // abort in CHARGE drops the setpoint
    plant_en = 1'b0;
    v_meas   = 16'sd0;
    plant_en = 1'b1;
    v_high   = 16'sd500;
    v_low    = 16'sd100;
    push_exp(ST_CHARGE, 1000, -1, 0);
    push_exp(ST_IDLE, 0, -1, 0);
    pulse_start();
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_eq("abort_chg_state", state, ST_IDLE);
    chk_eq("abort_chg_iset", i_set, 0);

    // abort together with start during HOLD
    plant_en = 1'b0;
    v_meas   = 16'sd0;
    plant_en = 1'b1;
    push_exp(ST_CHARGE, 1000, 10, 0);
    push_exp(ST_HOLD, 0, -1, 0);
    push_exp(ST_IDLE, 0, -1, 0);
    pulse_start();
    wait_state(ST_HOLD, 400, "abort_reach_hold");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk_eq("abort_hold_state", state, ST_IDLE);
    chk_eq("abort_hold_iset", i_set, 0);
    repeat (12) @(negedge clk);
    chk_eq("abort_no_restart", state, ST_IDLE);
    chk_eq("abort_no_busy", busy, 0);
    chk_eq("abort_cfg_err", cfg_err, 0);
    chk_eq("abort_sb_left", sb_q.size(), 0);

`ifdef CAP_SEQ_TIMEOUT_EN
    // stuck plant: timeout into FAULT, abort clears it
    plant_en = 1'b0;
    v_meas   = 16'sd0;
    push_exp(ST_CHARGE, 1000, 16, 0);
    push_exp(ST_FAULT, 0, -1, 0);
    push_exp(ST_IDLE, 0, -1, 0);
    pulse_start();
    wait_state(ST_FAULT, 200, "to_reach_fault");
    chk_eq("to_fault_flag", fault, 1);
    chk_eq("to_fault_iset", i_set, 0);
    repeat (8) @(negedge clk);
    chk_eq("to_fault_sticky", state, ST_FAULT);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_eq("to_abort_state", state, ST_IDLE);
    chk_eq("to_abort_fault", fault, 0);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cap_charge_sequencer.md
# cap_charge_sequencer

Sequencer for the capacitor integrator model: drives its signed current setpoint through charge, hold and discharge phases, and decides phase changes from the sampled output voltage once per sample period. Sits between the test/control logic (start/abort, thresholds) and the `circuio_c` datapath. It owns the sample-tick timebase (Ts = `TS_DIV` clocks) that the datapath and CSV logging share.

## Interface
- `TS_DIV`, 4: clocks per sample tick (≥2); 4 clocks at 1 GHz gives Ts = 4 ns.
- `IW`, 16: current-code width, signed.
- `VW`, 16: voltage-sample width, signed.
- `I_MAG`, 16'sd1000: magnitude of the charge/discharge current code.
- `HOLD_TICKS`, 8: ticks spent in HOLD.
- `NCYC_W`, 8: width of the cycle-count request/counter.
- `TO_TICKS`, 4096: phase timeout in ticks (only with `CAP_SEQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  sampling clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request; starts a sequence when idle.
- `abort`  in  1  forces return to IDLE.
- `n_cycles`  in  NCYC_W  charge/discharge cycles to run; 0 is treated as 1.
- `v_high`, `v_low`  in  VW each  signed thresholds; `v_high` must be greater than `v_low`.
- `v_meas`  in  VW  signed sample of `vout`.
- `i_set`  out  IW  signed current setpoint to the datapath.
- `sample_tick`  out  1  one-clock pulse every `TS_DIV` clocks.
- `state`  out  3  encoded FSM state.
- `busy`  out  1  high in CHARGE, HOLD and DISCHARGE.
- `done`  out  1  one-cycle pulse when the last cycle completes.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.
- `cyc_cnt`  out  NCYC_W  completed cycles in the current sequence.
- `fault`  out  1  sticky timeout flag (only with `CAP_SEQ_TIMEOUT_EN`).

## Operation
- States: IDLE=0, CHARGE=1, HOLD=2, DISCHARGE=3, DONE=4, FAULT=5.
- Setpoint per state: `i_set` = +`I_MAG` in CHARGE, −`I_MAG` in DISCHARGE, 0 in every other state.
- IDLE → CHARGE on `start` when `v_high` > `v_low`.
  - Otherwise `cfg_err` pulses and the FSM stays in IDLE.
  - `n_cycles` is latched at start.
  - The tick divider restarts at 0, so the first tick comes `TS_DIV` clocks later.
- CHARGE → HOLD on a tick with `v_meas` ≥ `v_high`.
- HOLD → DISCHARGE after `HOLD_TICKS` ticks.
- DISCHARGE → on a tick with `v_meas` ≤ `v_low`:
  - `cyc_cnt` increments;
  - go to CHARGE if `cyc_cnt`+1 < latched count, otherwise go to DONE.
- DONE → IDLE the next clock, pulsing `done`. `cyc_cnt` holds its value until the next accepted start.
- Threshold comparisons are signed, full `VW` width.
- Conditions are evaluated only on cycles where `sample_tick` is high. Non-tick cycles never change state (except for abort).
- `start` while busy is ignored; no `cfg_err`.
- `abort` in any state goes to IDLE on the next clock with `i_set`=0. It also clears `fault`.
- `abort` and `start` in the same cycle: abort wins and start is dropped.
- `cyc_cnt` saturates at 2^NCYC_W−1.

## Timing
- All outputs are registered.
- `state` and `i_set` change on the clock edge after the deciding tick: one clock of latency.
- `sample_tick` is free-running whenever not in reset, except that it is resynchronised on an accepted start.
- Reset values:
  - `state`=IDLE, `i_set`=0, `sample_tick`=0;
  - `busy`, `done`, `cfg_err`, `fault` = 0;
  - `cyc_cnt`=0;
  - tick divider = 0.
- Reset mid-phase drops `i_set` to 0 asynchronously.

## Configuration
- `CAP_SEQ_TIMEOUT_EN` defined:
  - a tick counter runs in CHARGE and DISCHARGE and is cleared on each phase entry;
  - when it reaches `TO_TICKS`, the FSM goes to FAULT with `i_set`=0 and sets `fault`;
  - FAULT exits only via `abort` or `rst`.
- Not defined: no timeout counter, no FAULT state, and `fault` is tied to 0.

## Structure
- Package `cap_seq_pkg` holds:
  - the state enum `cap_seq_state_e`;
  - default widths and `I_MAG`;
  - the state encoding constants.
- Sub-module `cap_tick_gen`: modulo-`TS_DIV` counter with a synchronous restart input, producing `sample_tick`.

## Test plan
- Reset with `rst`=1 for 3 clocks → all outputs at their reset values; `sample_tick` pulses every 4 clocks after release.
- Single cycle (`n_cycles`=1, `v_high`=500, `v_low`=100), with a model ramping `v_meas` ±50 per tick by the sign of `i_set`:
  - → CHARGE 10 ticks, HOLD 8 ticks, DISCHARGE 8 ticks;
  - → `done` pulses once and `cyc_cnt`=1.
- `n_cycles`=3 → `i_set` is +1000 three times and −1000 three times; `cyc_cnt` ends at 3.
- `start` with `v_high`=100, `v_low`=100 → `cfg_err` pulses for one clock; `state` stays 0.
- `abort` asserted during HOLD, together with `start` → next clock `state`=0 and `i_set`=0; no new sequence starts.
- With `CAP_SEQ_TIMEOUT_EN`, `TO_TICKS`=16 and `v_meas` stuck at 0 → FAULT after 16 CHARGE ticks with `fault`=1; `abort` then clears it.
